// File: rtl/pipelined_cla_adder16_if.sv
// Handshake and data bundle for the pipelined 16-bit carry-lookahead adder.
// The operand side (in_*, a, b, cin) and the result side (out_*, sum,
// cout, ovf) share one interface. The master is the operand source and
// result consumer. The slave is the adder itself.
interface pipelined_cla_adder16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/pipelined_cla_adder16.sv
// Two-stage pipelined 16-bit carry-lookahead adder.
// Stage 1 registers per-bit propagate/generate terms and the carry-in.
// Stage 2 resolves the carries through a two-level 4-bit lookahead tree,
// then registers sum, carry-out and signed overflow.
// Valid/ready handshakes on both sides give a capacity of two
// transactions in flight.

// 4-bit lookahead carry unit. It produces the carries out of each bit
// position from the incoming carry, plus the group propagate and group
// generate terms that the next level of the tree uses.
module ClaLookahead4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       pg_o,
    output logic       gg_o
);

    // Flattened lookahead equations: every carry comes straight from p/g and c_i.
    always_comb begin
        c_o[0] = g_i[0]
               | (p_i[0] & c_i);
        c_o[1] = g_i[1]
               | (p_i[1] & g_i[0])
               | (p_i[1] & p_i[0] & c_i);
        c_o[2] = g_i[2]
               | (p_i[2] & g_i[1])
               | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & c_i);
        c_o[3] = g_i[3]
               | (p_i[3] & g_i[2])
               | (p_i[3] & p_i[2] & g_i[1])
               | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
               | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
        pg_o   = &p_i;
        gg_o   = g_i[3]
               | (p_i[3] & g_i[2])
               | (p_i[3] & p_i[2] & g_i[1])
               | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    end

endmodule

module pipelined_cla_adder16 (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_cla_adder16_if.slave        bus
);

    // Stage 1 state: per-bit propagate/generate, carry-in, occupancy
    logic [15:0] pBits_q,  pBits_d;
    logic [15:0] gBits_q,  gBits_d;
    logic        cin_q,    cin_d;
    logic        s1Valid_q, s1Valid_d;

    // Stage 2 state: registered result and occupancy
    logic [15:0] sum_q,    sum_d;
    logic        cout_q,   cout_d;
    logic        ovf_q,    ovf_d;
    logic        outValid_q, outValid_d;

    // Handshake decode
    logic        s2Adv;
    logic        s1Move;
    logic        inReady;
    logic        inXfer;

    // Lookahead tree wiring
    logic [3:0]  grpP;
    logic [3:0]  grpG;
    logic [3:0]  grpCarry;
    logic [3:0]  groupCin;
    logic [3:0]  bitCarry [4];
    logic        unusedTopP;
    logic        unusedTopG;
    logic [16:0] carry;
    logic [15:0] sumNext;
    logic        coutNext;
    logic        ovfNext;

    // Stage 2 advances whenever it is empty or its result is being taken.
    // Stage 1 may accept when it is empty or is about to move forward.
    always_comb begin
        s2Adv   = !outValid_q | bus.out_ready;
        s1Move  = s1Valid_q & s2Adv;
        inReady = !s1Valid_q | s2Adv;
        inXfer  = bus.in_valid & inReady;
    end

    // First level: one lookahead unit per 4-bit group. Each gets its group carry-in.
    for (genvar k = 0; k < 4; k++) begin : gGroup
        ClaLookahead4 uGroup (
            .p_i  (pBits_q[4*k +: 4]),
            .g_i  (gBits_q[4*k +: 4]),
            .c_i  (groupCin[k]),
            .c_o  (bitCarry[k]),
            .pg_o (grpP[k]),
            .gg_o (grpG[k])
        );
    end

    // Second level: turns group propagate/generate into c4, c8, c12, c16.
    ClaLookahead4 uTop (
        .p_i  (grpP),
        .g_i  (grpG),
        .c_i  (cin_q),
        .c_o  (grpCarry),
        .pg_o (unusedTopP),
        .gg_o (unusedTopG)
    );

    assign groupCin = {grpCarry[2:0], cin_q};

    // Assemble the bit-carry vector, then form sum, carry-out and overflow.
    always_comb begin
        carry[0] = cin_q;
        for (int k = 0; k < 4; k++) begin
            carry[4*k+1 +: 4] = bitCarry[k];
        end
        sumNext  = pBits_q ^ carry[15:0];
        coutNext = grpCarry[3];
        ovfNext  = carry[15] ^ carry[16];
    end

    // Stage 1 next state: capture on input transfer, otherwise empty when moving on.
    always_comb begin
        pBits_d   = pBits_q;
        gBits_d   = gBits_q;
        cin_d     = cin_q;
        s1Valid_d = s1Valid_q;
        if (inXfer) begin
            pBits_d   = bus.a ^ bus.b;
            gBits_d   = bus.a & bus.b;
            cin_d     = bus.cin;
            s1Valid_d = 1'b1;
        end else if (s1Move) begin
            s1Valid_d = 1'b0;
        end
    end

    // Stage 2 next state: load from stage 1, or drain when the consumer takes the result.
    always_comb begin
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        if (s1Move) begin
            sum_d      = sumNext;
            cout_d     = coutNext;
            ovf_d      = ovfNext;
            outValid_d = 1'b1;
        end else if (s2Adv) begin
            outValid_d = 1'b0;
        end
    end

    // Pipeline registers. Reset empties both stages immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pBits_q    <= '0;
            gBits_q    <= '0;
            cin_q      <= 1'b0;
            s1Valid_q  <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            pBits_q    <= pBits_d;
            gBits_q    <= gBits_d;
            cin_q      <= cin_d;
            s1Valid_q  <= s1Valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/pipelined_cla_adder16.md
# pipelined_cla_adder16

Two-stage pipelined 16-bit carry-lookahead adder with valid/ready handshakes on both sides. Stage 1 registers per-bit propagate/generate terms. Stage 2 applies a two-level 4-bit lookahead tree to produce group and bit carries, and registers sum, carry-out and signed overflow. It sits between the operand source (ALU operand mux) and the writeback/result consumer, and is the datapath that instantiates the 4-bit lookahead carry units.

## Interface
- No parameters; datapath width fixed at 16 bits (four 4-bit groups).

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, cin valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  16  operand A
- b  input  16  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- sum  output  16  a + b + cin, low 16 bits
- cout  output  1  carry out of bit 15
- ovf  output  1  two's-complement overflow = carry into bit 15 XOR cout

## Operation
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- Stage 1 (S1) captures the following on input transfer:
  - P[i] = a[i] ^ b[i]
  - G[i] = a[i] & b[i]
  - cin
  - s1_valid set to 1
- Stage 2 (S2) carry logic, all combinational from the S1 registers:
  - Four 4-bit lookahead units take P/G slices [3:0], [7:4], [11:8], [15:12]. Each produces group p and group g.
  - A second-level 4-bit lookahead unit takes the group p/g vectors and cin. It produces group carries c4, c8, c12 and c16 (= cout).
  - Each 4-bit unit receives its group carry-in: cin, c4, c8 or c12. Its four carry outputs give bit carries c[i+1].
  - sum[i] = P[i] ^ c[i], where c[0] = cin. ovf = c[15] ^ c[16].
  - Carries must come from this P/G lookahead structure. Behavioural "+" on a and b is not permitted.
- S2 registers sum, cout and ovf and sets out_valid when S1 holds valid data and S2 can advance.
- Advance conditions:
  - s2_adv = !out_valid | out_ready
  - S1 → S2 transfer = s1_valid & s2_adv
- in_ready = !s1_valid | s2_adv. This is combinational from state and out_ready. It has no dependency on in_valid.
- S1 clears s1_valid when it transfers to S2 and no new input arrives in the same cycle. A simultaneous transfer out and new capture leaves s1_valid at 1.
- out_valid clears on an output transfer when S1 has nothing to move in. It stays 1 when S1 moves in on the same cycle.
- Holding and ordering:
  - While out_valid & !out_ready, sum, cout and ovf hold stable.
  - While S1 is full and stalled, S1 contents hold.
  - Results emerge in input order. No transaction is dropped or duplicated.
- Capacity is 2 in-flight transactions. When both stages are full and out_ready = 0, in_ready = 0.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, s1_valid = 0.
  - sum = 16'h0000, cout = 0, ovf = 0.
  - P and G registers = 0.
  - in_ready = 1 from the reset-deassertion cycle onward.
- Reset asserted mid-operation discards all in-flight transactions immediately, without waiting for a clock edge.
- Latency: an operand accepted at edge N produces out_valid = 1 after edge N+1, provided out_ready was high or the output was empty.
- Throughput: one result per cycle with out_ready held high.
- Back-pressure:
  - The first stalled cycle keeps in_ready high while S1 is empty, so one extra transfer is absorbed.
  - in_ready falls once both stages are full.
  - in_ready returns combinationally in the same cycle out_ready rises.
- Simultaneous input and output transfer with both stages full is legal and keeps the pipeline full.

## Test plan
- Wrap-around: a = 16'hFFFF, b = 16'h0001, cin = 0 → sum = 16'h0000, cout = 1, ovf = 0. out_valid rises one cycle after the accepting edge.
- Positive overflow: a = 16'h7FFF, b = 16'h0001, cin = 0 → sum = 16'h8000, cout = 0, ovf = 1. Negative overflow: a = 16'h8000, b = 16'h8000 → sum = 16'h0000, cout = 1, ovf = 1.
- Full ripple through all groups via cin: a = 16'hFFFF, b = 16'h0000, cin = 1 → sum = 16'h0000, cout = 1, ovf = 0. Then a = 16'h1234, b = 16'h4321, cin = 1 → sum = 16'h5556, cout = 0.
- Streaming: 8 back-to-back random transfers with out_ready = 1 → 8 results on consecutive cycles, in order, each matching a reference model.
- Back-pressure: out_ready = 0 while offering 3 transfers → exactly 2 accepted and in_ready = 0 afterward, with output values stable. Raising out_ready then delivers results in order, and the third transfer is accepted in the same cycle out_ready rises.
- Reset mid-flight: assert rst_n = 0 between edges with 2 transactions in flight → out_valid and all outputs drop to 0 without a clock. After release, no stale result ever appears.
